morse_tx_scheduler: RTL and testbench
=====================================

MORSE_TX_SCHEDULER -- requirements
Module: morse_tx_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clock cycles per Morse symbol period (0.5 s at 50 MHz); legal range 2..2^26-1.
REQ-002 SHALL have parameter PATTERN_W, default 16, width of the Morse bit pattern.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-requester encode request, level, held until granted.
REQ-006 SHALL have port letter0  input  3  requester 0 letter code (S..Z = 0..7).
REQ-007 SHALL have port letter1  input  3  requester 1 letter code.
REQ-008 SHALL have port grant  output  2  one-hot, single-cycle acknowledge of the captured request.
REQ-009 SHALL have port owner  output  1  index of the requester currently being served.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse on completion of a letter.
REQ-012 SHALL have port morse_code  output  1  serial Morse output, MSB first.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, GAP; all outputs registered.
REQ-014 In IDLE with req!=0 at a rising edge, SHALL grant one requester, load its pattern, enter SHIFT, clear tick counter and bit counter.
REQ-015 Arbitration SHALL be round-robin: if both request, the requester not served last wins; a single request wins regardless of history.
REQ-016 grant[i] SHALL be high for exactly the one cycle after the granting edge; owner SHALL update on the same edge.
REQ-017 letterN SHALL be sampled only at the granting edge; changes afterwards SHALL NOT affect the letter in flight.
REQ-018 req deasserted before grant SHALL be treated as withdrawn; req during busy SHALL be ignored until IDLE.
REQ-019 Pattern table: S=1010100000000000, T=1110000000000000, U=1010111000000000, V=1010101110000000, W=1011101110000000, X=1110101011100000, Y=1110101110111000, Z=1110111010100000.
REQ-020 In SHIFT, morse_code SHALL equal shift-register MSB; one tick = TICK_DIV cycles; each tick shifts left, filling 0.
REQ-021 SHIFT SHALL last exactly PATTERN_W ticks (16*TICK_DIV cycles), then go to GAP (macro on) or IDLE (macro off).
REQ-022 GAP SHALL drive morse_code=0 for exactly 3 ticks, then go to IDLE.
REQ-023 done SHALL pulse high in the first IDLE cycle; a pending req is granted no earlier than the edge ending that cycle.
REQ-024 Tick counter SHALL wrap from TICK_DIV-1 to 0 and run only when busy.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, grant=0, owner=0, busy=0, done=0, morse_code=0, counters=0, last-served=1 (so requester 0 wins first tie).
REQ-026 Reset mid-letter SHALL abort it with no done pulse; deassertion SHALL resume in IDLE.

Configuration
REQ-027 Macro MORSE_SCHED_LETTER_GAP_EN defined: GAP state present per REQ-022.
REQ-028 Macro MORSE_SCHED_LETTER_GAP_EN undefined: GAP state and its logic absent; SHIFT exits directly to IDLE.

Structure
REQ-029 Package morse_pkg SHALL hold letter codes, the pattern table constants, PATTERN_W default, and FSM state encodings.
REQ-030 Tick prescaler SHALL be sub-module morse_tick_gen (inputs clock, reset, enable; output single-cycle tick).

Verification (TICK_DIV=4)
REQ-031 req=01, letter0=1 (T) -> grant=01 one cycle, morse_code 1,1,1 then 0 each for 4 cycles, done 64 cycles after grant (76 with gap).
REQ-032 req=11 from reset -> grant=01 first, req1 held -> grant=10 the cycle after done; repeat -> alternate 01/10.
REQ-033 letter0 changed from 0 to 7 one cycle after grant -> output remains S pattern 1010100000000000.
REQ-034 reset asserted mid-SHIFT -> morse_code, busy 0 immediately, no done; after release req=10 -> grant=10.
REQ-035 req1 pulsed during busy then dropped before IDLE -> no grant issued, busy stays 0 after done.
REQ-036 macro off, letter Z -> done exactly 64 cycles after grant, morse_code 0 throughout the following IDLE.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit scheduler: letter codes, the
// S..Z pattern table, the default pattern width and the FSM state encoding.
// The GAP state exists only when MORSE_SCHED_LETTER_GAP_EN is defined.
package morse_pkg;

  localparam int unsigned PATTERN_W_DEF = 16;
  localparam int unsigned PAT_LEN       = 16;
  localparam int unsigned GAP_TICKS     = 3;

  // Letter codes as presented on letter0/letter1
  localparam logic [2:0] LETTER_S = 3'd0;
  localparam logic [2:0] LETTER_T = 3'd1;
  localparam logic [2:0] LETTER_U = 3'd2;
  localparam logic [2:0] LETTER_V = 3'd3;
  localparam logic [2:0] LETTER_W = 3'd4;
  localparam logic [2:0] LETTER_X = 3'd5;
  localparam logic [2:0] LETTER_Y = 3'd6;
  localparam logic [2:0] LETTER_Z = 3'd7;

  // On/off keying patterns, MSB transmitted first
  localparam logic [PAT_LEN-1:0] PAT_S = 16'b1010100000000000;
  localparam logic [PAT_LEN-1:0] PAT_T = 16'b1110000000000000;
  localparam logic [PAT_LEN-1:0] PAT_U = 16'b1010111000000000;
  localparam logic [PAT_LEN-1:0] PAT_V = 16'b1010101110000000;
  localparam logic [PAT_LEN-1:0] PAT_W = 16'b1011101110000000;
  localparam logic [PAT_LEN-1:0] PAT_X = 16'b1110101011100000;
  localparam logic [PAT_LEN-1:0] PAT_Y = 16'b1110101110111000;
  localparam logic [PAT_LEN-1:0] PAT_Z = 16'b1110111010100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef MORSE_SCHED_LETTER_GAP_EN
    GAP   = 2'd2,
`endif
    SHIFT = 2'd1
  } state_t;

  function automatic logic [PAT_LEN-1:0] morse_pattern(input logic [2:0] letter);
    logic [PAT_LEN-1:0] pat;
    case (letter)
      LETTER_S: pat = PAT_S;
      LETTER_T: pat = PAT_T;
      LETTER_U: pat = PAT_U;
      LETTER_V: pat = PAT_V;
      LETTER_W: pat = PAT_W;
      LETTER_X: pat = PAT_X;
      LETTER_Y: pat = PAT_Y;
      LETTER_Z: pat = PAT_Z;
      default:  pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Symbol-period prescaler: while enabled, emits a one-cycle tick every
// TICK_DIV cycles. The count is held at zero whenever disabled, so the first
// tick after enabling arrives exactly TICK_DIV cycles later.
module morse_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: wraps at TICK_DIV-1, cleared while idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/morse_tx_scheduler.sv
// Two-requester Morse letter transmitter. A round-robin arbiter grants one
// requester from IDLE, its letter pattern is shifted out MSB first, one bit
// per TICK_DIV cycles, and done pulses on return to IDLE.
// Optional feature: define MORSE_SCHED_LETTER_GAP_EN to add a 3-tick silent
// GAP state after each letter.
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned PATTERN_W = PATTERN_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [2:0] letter0,
  input  logic [2:0] letter1,
  output logic [1:0] grant,
  output logic       owner,
  output logic       busy,
  output logic       done,
  output logic       morse_code
);

`ifdef MORSE_SCHED_LETTER_GAP_EN
  localparam int unsigned BIT_MAX = (PATTERN_W > GAP_TICKS) ? PATTERN_W : GAP_TICKS;
`else
  localparam int unsigned BIT_MAX = PATTERN_W;
`endif
  localparam int unsigned BIT_W = $clog2(BIT_MAX + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PATTERN_W - 1);
`ifdef MORSE_SCHED_LETTER_GAP_EN
  localparam logic [BIT_W-1:0] LAST_GAP = BIT_W'(GAP_TICKS - 1);
`endif

  state_t               state_r;
  logic [PATTERN_W-1:0] shift_r;
  logic [BIT_W-1:0]     bit_r;
  logic [1:0]           grant_r;
  logic                 owner_r;
  logic                 last_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 morse_r;

  logic                 tick_s;
  logic                 win_s;
  logic [2:0]           letter_s;
  logic [PAT_LEN-1:0]   pat_s;
  logic [PATTERN_W-1:0] load_s;
  logic [PATTERN_W-1:0] next_shift_s;

  morse_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(busy_r),
    .tick  (tick_s)
  );

  // Round-robin winner: a lone request wins, a tie goes to the one not served last
  always_comb begin
    win_s = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_r;
      default: win_s = 1'b0;
    endcase
  end

  // Letter of the winning requester, MSB-aligned into the shift register width
  always_comb begin
    if (win_s) begin
      letter_s = letter1;
    end else begin
      letter_s = letter0;
    end
    pat_s        = morse_pattern(letter_s);
    load_s       = PATTERN_W'({pat_s, {PATTERN_W{1'b0}}} >> PAT_LEN);
    next_shift_s = shift_r << 1;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      shift_r <= '0;
      bit_r   <= '0;
      grant_r <= 2'b00;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      morse_r <= 1'b0;
    end else begin
      grant_r <= 2'b00;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          morse_r <= 1'b0;
          if (req != 2'b00) begin
            state_r <= SHIFT;
            grant_r <= win_s ? 2'b10 : 2'b01;
            owner_r <= win_s;
            last_r  <= win_s;
            busy_r  <= 1'b1;
            shift_r <= load_s;
            morse_r <= load_s[PATTERN_W-1];
            bit_r   <= '0;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            shift_r <= next_shift_s;
            if (bit_r == LAST_BIT) begin
              bit_r   <= '0;
              morse_r <= 1'b0;
`ifdef MORSE_SCHED_LETTER_GAP_EN
              state_r <= GAP;
`else
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
`endif
            end else begin
              bit_r   <= bit_r + BIT_W'(1);
              morse_r <= next_shift_s[PATTERN_W-1];
            end
          end
        end
`ifdef MORSE_SCHED_LETTER_GAP_EN
        GAP: begin
          morse_r <= 1'b0;
          if (tick_s) begin
            if (bit_r == LAST_GAP) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              bit_r   <= '0;
            end else begin
              bit_r <= bit_r + BIT_W'(1);
            end
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          morse_r <= 1'b0;
          bit_r   <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign owner      = owner_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign morse_code = morse_r;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler (TICK_DIV=4). The stimulus process
// predicts each grant (round-robin) and the letter's dot/dash waveform and
// queues it; an independent monitor pops on every grant and checks the whole
// letter cycle by cycle.
module tb_morse_tx_scheduler;

  localparam int TICK_DIV  = 4;
  localparam int PW        = 16;
  localparam int SHIFT_CYC = PW * TICK_DIV;
`ifdef MORSE_SCHED_LETTER_GAP_EN
  localparam int LC = SHIFT_CYC + 3 * TICK_DIV;
`else
  localparam int LC = SHIFT_CYC;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [2:0] letter0;
  logic [2:0] letter1;
  logic [1:0] grant;
  logic       owner;
  logic       busy;
  logic       done;
  logic       morse_code;

  typedef struct {
    logic [1:0]  g;
    logic        o;
    logic [15:0] pat;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   m_active = 1'b0;
  bit   m_handled;
  int   m_t = 0;
  int   last_done = -100;
  exp_t m_cur;
  logic last_m;

  morse_tx_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .letter0   (letter0),
    .letter1   (letter1),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .done      (done),
    .morse_code(morse_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // International Morse for S..Z
  function automatic string letter_code(input logic [2:0] l);
    case (l)
      3'd0:    return "...";
      3'd1:    return "-";
      3'd2:    return "..-";
      3'd3:    return "...-";
      3'd4:    return ".--";
      3'd5:    return "-..-";
      3'd6:    return "-.--";
      default: return "--..";
    endcase
  endfunction

  // Dot = on 1 unit, dash = on 3 units, each followed by 1 unit off
  function automatic logic [15:0] build_pattern(input string s);
    logic [15:0] p;
    int pos;
    p = 16'h0000;
    pos = 15;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") begin
        p[pos] = 1'b1; p[pos-1] = 1'b1; p[pos-2] = 1'b1;
        pos -= 4;
      end else begin
        p[pos] = 1'b1;
        pos -= 2;
      end
    end
    return p;
  endfunction

  function automatic logic exp_bit(input logic [15:0] p, input int t);
    if (t < SHIFT_CYC) return p[15 - t / TICK_DIV];
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard on each grant and follows the letter to done
  always @(negedge clock) begin
    cyc++;
    m_handled = 1'b0;
    if (reset) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_t++;
        m_handled = 1'b1;
        check("grant_single_cycle", 32'(grant), 32'd0);
        if (m_t < LC) begin
          check("morse_bit", 32'(morse_code), 32'(exp_bit(m_cur.pat, m_t)));
          check("busy_active", 32'(busy), 32'd1);
          check("done_early", 32'(done), 32'd0);
          check("owner_hold", 32'(owner), 32'(m_cur.o));
        end else begin
          check("done_pulse", 32'(done), 32'd1);
          check("busy_end", 32'(busy), 32'd0);
          check("morse_end", 32'(morse_code), 32'd0);
          m_active = 1'b0;
          last_done = cyc;
        end
      end
      if (!m_handled && grant != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          m_cur = exp_q.pop_front();
          check("grant_value", 32'(grant), 32'(m_cur.g));
          check("owner_value", 32'(owner), 32'(m_cur.o));
          check("morse_first", 32'(morse_code), 32'(exp_bit(m_cur.pat, 0)));
          check("busy_grant", 32'(busy), 32'd1);
          if (m_cur.b2b) check("b2b_grant_time", 32'(cyc - last_done), 32'd1);
          m_active = 1'b1;
          m_t = 0;
        end
      end else if (!m_handled) begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_morse", 32'(morse_code), 32'd0);
      end
    end
  end

  task automatic wait_grant(input logic w, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < LC + 40 && !got; k++) begin
      @(negedge clock);
      if (grant[w]) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int k = 0; k < LC + 40 && !got; k++) begin
      @(negedge clock);
      if (!busy) got = 1'b1;
    end
    check("idle_wait", 32'(got), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic flip_letter(input logic w);
    if (w) letter1 = letter1 ^ 3'd7;
    else   letter0 = letter0 ^ 3'd7;
  endtask

  task automatic do_txn(input logic [1:0] r, input logic [2:0] l0, input logic [2:0] l1, input bit pulse);
    logic w;
    exp_t e;
    @(negedge clock);
    letter0 = l0;
    letter1 = l1;
    w = (r == 2'b11) ? ~last_m : r[1];
    e.g = w ? 2'b10 : 2'b01;
    e.o = w;
    e.pat = build_pattern(letter_code(w ? l1 : l0));
    e.b2b = 1'b0;
    exp_q.push_back(e);
    last_m = w;
    if (r == 2'b11) begin
      e.g = w ? 2'b01 : 2'b10;
      e.o = ~w;
      e.pat = build_pattern(letter_code(w ? l0 : l1));
      e.b2b = 1'b1;
      exp_q.push_back(e);
      last_m = ~w;
    end
    req = r;
    wait_grant(w, "grant_wait");
    req[w] = 1'b0;
    flip_letter(w);
    if (r == 2'b11) begin
      wait_grant(~w, "grant_wait_second");
      req[~w] = 1'b0;
      flip_letter(~w);
    end else if (pulse) begin
      repeat (8) @(negedge clock);
      req[~w] = 1'b1;
      repeat (4) @(negedge clock);
      req[~w] = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr;
    exp_t e;
    reset = 1'b1;
    req = 2'b00;
    letter0 = 3'd0;
    letter1 = 3'd0;
    last_m = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_morse", 32'(morse_code), 32'd0);
    #1 reset = 1'b0;

    do_txn(2'b11, 3'd2, 3'd5, 1'b0);
    do_txn(2'b01, 3'd0, 3'd3, 1'b0);
    do_txn(2'b01, 3'd1, 3'd4, 1'b1);
    do_txn(2'b10, 3'd0, 3'd7, 1'b1);
    do_txn(2'b11, 3'd6, 3'd1, 1'b0);
    for (int n = 0; n < 10; n++) begin
      rr = 2'($urandom_range(1, 3));
      do_txn(rr, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Abort a letter mid-shift with reset
    @(negedge clock);
    letter0 = 3'd6;
    e.g = 2'b01; e.o = 1'b0; e.pat = build_pattern(letter_code(3'd6)); e.b2b = 1'b0;
    exp_q.push_back(e);
    last_m = 1'b0;
    req = 2'b01;
    wait_grant(1'b0, "grant_wait_abort");
    req = 2'b00;
    repeat (20) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_morse", 32'(morse_code), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_owner", 32'(owner), 32'd0);
    exp_q.delete();
    last_m = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    do_txn(2'b10, 3'd3, 3'd7, 1'b0);
    do_txn(2'b11, 3'd4, 3'd0, 1'b0);

    repeat (4) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
